// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide unit.
// Runs all eight M-extension operations in a fixed 33-cycle latency and
// returns the result with a write strobe for the register unit.
//
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   Start, Funct3  request and operation select (sampled when not in CALC)
//   RFrs1, RFrs2   operand A (multiplicand/dividend), operand B
//   rdIn           destination register index
//   Busy, Done     handshake: Busy in CALC/DONE, Done one-cycle result valid
//   Result, rdOut  registered result and latched destination
//   RFWr           register write enable (Done && rdOut != 0)
//
// state | meaning
// IDLE  | waiting for Start
// CALC  | 32 shift/add or restoring-divide steps, then one sign-fix cycle
// DONE  | Result valid for one cycle; a Start here begins the next op
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] RFrs1,
  input  logic [XLEN-1:0] RFrs2,
  input  logic [4:0]      rdIn,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result,
  output logic [4:0]      rdOut,
  output logic            RFWr
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [5:0]        cnt_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_q, b_q, result_q;
  logic [2*XLEN-1:0] acc_q;
  logic              neg_q;

  logic              accept, steps_done;
  logic              a_sgn, b_sgn, neg_d;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   quo, rem, res_fix;

  // A request in DONE is accepted so that a held Start gives back-to-back ops.
  assign accept     = Start && (state_q != S_CALC);
  assign steps_done = (cnt_q == 6'd32);

  // Operand conditioning at the accept edge.
  always_comb begin
    a_sgn = RFrs1[XLEN-1] && ((Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                              (Funct3[2] && !Funct3[0]));
    b_sgn = RFrs2[XLEN-1] && ((Funct3 == 3'b001) || (Funct3[2] && !Funct3[0]));
    a_mag = a_sgn ? -RFrs1 : RFrs1;
    b_mag = b_sgn ? -RFrs2 : RFrs2;
    if (!Funct3[2])
      neg_d = a_sgn ^ b_sgn;
    else if (!Funct3[1])
      // A zero divisor must leave the all-ones quotient unsigned.
      neg_d = (a_sgn ^ b_sgn) && (RFrs2 != '0);
    else
      neg_d = a_sgn;
  end

  // One iteration. Multiply: acc = {product_hi, multiplier}, shift right.
  // Divide: acc = {remainder, dividend/quotient}, shift left, quotient in LSB.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? a_q : '0)};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, b_q};
    acc_step  = acc_q;
    if (!op_q[2])
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    else if (!div_diff[XLEN])
      acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // Sign correction and result selection, registered on entry to DONE.
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo      = acc_q[XLEN-1:0];
    rem      = acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:         res_fix = acc_q[XLEN-1:0];
      3'b100, 3'b101: res_fix = neg_q ? -quo : quo;
      3'b110, 3'b111: res_fix = neg_q ? -rem : rem;
      default:        res_fix = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_CALC;
      S_CALC:  if (steps_done) state_d = S_DONE;
      S_DONE:  state_d = Start ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy   = (state_q != S_IDLE);
    Done   = (state_q == S_DONE);
    RFWr   = Done && (rd_q != 5'd0);
    Result = result_q;
    rdOut  = rd_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      op_q  <= Funct3;
      rd_q  <= rdIn;
      a_q   <= a_mag;
      b_q   <= b_mag;
      neg_q <= neg_d;
      acc_q <= Funct3[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
    end else if (state_q == S_CALC) begin
      if (!steps_done) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 6'd1;
      end else begin
        result_q <= res_fix;
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start;
  logic [2:0]  Funct3;
  logic [31:0] RFrs1, RFrs2;
  logic [4:0]  rdIn;
  logic        Busy, Done, RFWr;
  logic [31:0] Result;
  logic [4:0]  rdOut;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  mdu_seq #(.XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Funct3(Funct3),
    .RFrs1(RFrs1), .RFrs2(RFrs2), .rdIn(rdIn),
    .Busy(Busy), .Done(Done), .Result(Result), .rdOut(rdOut), .RFWr(RFWr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives one request (also releasing RST on the same edge), then checks
  // latency, result, destination and the one-cycle write strobe.
  task automatic run_op(input vec_t v, input string nm);
    int lat;
    @(negedge CLK);
    RST = 1'b0; Start = 1'b1;
    Funct3 = v.f; RFrs1 = v.a; RFrs2 = v.b; rdIn = v.rd;
    @(posedge CLK); #1;
    Start = 1'b0;
    RFrs1 = $urandom; RFrs2 = $urandom; rdIn = 5'($urandom); Funct3 = 3'($urandom);
    chk({nm, "_busy"}, {31'b0, Busy}, 32'd1);
    lat = 0;
    while (Done !== 1'b1 && lat < 60) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk({nm, "_lat"}, lat, 32'd33);
    chk({nm, "_res"}, Result, v.exp);
    chk({nm, "_rd"}, {27'b0, rdOut}, {27'b0, v.rd});
    chk({nm, "_rfwr"}, {31'b0, RFWr}, {31'b0, (v.rd != 5'd0)});
    @(posedge CLK); #1;
    chk({nm, "_done_off"}, {30'b0, Done, RFWr}, 32'd0);
    chk({nm, "_idle"}, {31'b0, Busy}, 32'd0);
    chk({nm, "_hold"}, Result, v.exp);
  endtask

  initial begin
    int dones, done_e, d1, d2, busy_gap;
    logic [31:0] res1, res2;
    logic [4:0]  rdq;
    vec_t v;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF};
    vecs[6]  = '{3'b101, 32'hFFFFFFFF, 32'd2,        5'd7,  32'h7FFFFFFF};
    vecs[7]  = '{3'b111, 32'd68,       32'd7,        5'd8,  32'd5};
    vecs[8]  = '{3'b100, 32'd68,       32'd0,        5'd9,  32'hFFFFFFFF};
    vecs[9]  = '{3'b110, 32'd68,       32'd0,        5'd10, 32'd68};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0};
    vecs[12] = '{3'b000, 32'h00001234, 32'h00000010, 5'd0,  32'h00012340};
    vecs[13] = '{3'b100, 32'hFFFFFFF9, 32'd0,        5'd13, 32'hFFFFFFFF};
    vecs[14] = '{3'b110, 32'hFFFFFFF9, 32'd0,        5'd14, 32'hFFFFFFF9};
    vecs[15] = '{3'b001, 32'hFFFFFFFF, 32'd2,        5'd15, 32'hFFFFFFFF};
    vecs[16] = '{3'b100, 32'd7,        32'hFFFFFFFE, 5'd16, 32'hFFFFFFFD};

    RST = 1'b1; Start = 1'b0; Funct3 = '0; RFrs1 = '0; RFrs2 = '0; rdIn = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_done", {30'b0, Done, RFWr}, 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_rd", {27'b0, rdOut}, 32'd0);

    for (int i = 0; i < 17; i++) run_op(vecs[i], $sformatf("v%0d", i));

    // Starts during CALC are dropped: DIVU 100/7 with stray pulses at cycles 5 and 20.
    @(negedge CLK);
    Start = 1'b1; Funct3 = 3'b101; RFrs1 = 32'd100; RFrs2 = 32'd7; rdIn = 5'd9;
    @(posedge CLK); #1;
    dones = 0; done_e = 0; res1 = '0; rdq = '0;
    for (int e = 1; e <= 50; e++) begin
      @(negedge CLK);
      Start = (e == 5 || e == 20);
      RFrs1 = $urandom; RFrs2 = $urandom; Funct3 = 3'b000; rdIn = 5'd1;
      @(posedge CLK); #1;
      if (Done === 1'b1) begin
        dones++;
        if (dones == 1) begin res1 = Result; rdq = rdOut; done_e = e; end
      end
    end
    Start = 1'b0;
    chk("ign_dones", dones, 32'd1);
    chk("ign_lat", done_e, 32'd33);
    chk("ign_res", res1, 32'd14);
    chk("ign_rd", {27'b0, rdq}, 32'd9);

    // Start held high: MUL 3x4 repeats every 34 cycles without dropping Busy.
    @(negedge CLK);
    Start = 1'b1; Funct3 = 3'b000; RFrs1 = 32'd3; RFrs2 = 32'd4; rdIn = 5'd3;
    @(posedge CLK); #1;
    d1 = 0; d2 = 0; busy_gap = 0; res2 = '0;
    for (int e = 1; e <= 80; e++) begin
      @(posedge CLK); #1;
      if (Busy !== 1'b1) busy_gap++;
      if (Done === 1'b1) begin
        if (d1 == 0) d1 = e;
        else begin d2 = e; res2 = Result; break; end
      end
    end
    @(negedge CLK);
    Start = 1'b0;
    @(posedge CLK); #1;
    chk("held_first", d1, 32'd33);
    chk("held_period", d2 - d1, 32'd34);
    chk("held_res", res2, 32'd12);
    chk("held_busy", busy_gap, 32'd0);
    chk("held_idle", {31'b0, Busy}, 32'd0);

    // Reset on the 10th CALC edge aborts; a MUL 35x88 starts right after.
    @(negedge CLK);
    Start = 1'b1; Funct3 = 3'b000; RFrs1 = 32'd5; RFrs2 = 32'd6; rdIn = 5'd4;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("abort_busy", {31'b0, Busy}, 32'd0);
    chk("abort_done", {30'b0, Done, RFWr}, 32'd0);
    chk("abort_result", Result, 32'd0);
    v = '{3'b000, 32'd35, 32'd88, 5'd7, 32'd3080};
    run_op(v, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
